// File: rtl/noc_trace_buffer.sv
// rtl/noc_trace_buffer.sv - inline val/yum NoC tap with triggered circular trace capture (optional timestamps: NOC_TRACE_TIMESTAMP_EN)
module noc_trace_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64,
    parameter int TS_WIDTH   = 16,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          din_msg,
    input  logic                           din_val,
    output logic                           din_yum,
    output logic [DATA_WIDTH-1:0]          dout_msg,
    output logic                           dout_val,
    input  logic                           dout_yum,
    input  logic                           cfg_arm,
    input  logic                           cfg_stop,
    input  logic                           cfg_wrap,
    input  logic [DATA_WIDTH-1:0]          trig_mask,
    input  logic [DATA_WIDTH-1:0]          trig_value,
    input  logic                           rd_en,
    output logic                           rd_val,
    output logic [DATA_WIDTH+TS_WIDTH-1:0] rd_data,
    output logic [1:0]                     state,
    output logic [$clog2(DEPTH):0]         cap_count,
    output logic [OVF_WIDTH-1:0]           ovf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef NOC_TRACE_TIMESTAMP_EN
    localparam int MW = DATA_WIDTH + TS_WIDTH;
`else
    localparam int MW = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [MW-1:0]   mem [DEPTH];
    logic [MW-1:0]   wr_entry;
    logic            transfer, trig_hit, full, arm_go, wr_go, rd_go, last_fill;

    // The link itself is never touched by the capture engine
    assign dout_msg = din_msg;
    assign dout_val = din_val;
    assign din_yum  = dout_yum;
    assign state    = state_q;

    assign transfer  = din_val & dout_yum;
    assign trig_hit  = ((din_msg & trig_mask) == (trig_value & trig_mask));
    assign full      = (cap_count == CW'(DEPTH));
    assign arm_go    = cfg_arm & ((state_q == S_IDLE) | (state_q == S_DONE));
    // Stop beats the trigger in ARMED; in CAPTURE the stop-cycle flit is kept.
    // A full buffer with wrap off never accepts another write.
    assign wr_go     = transfer & (((state_q == S_ARMED) & trig_hit & ~cfg_stop) |
                                   ((state_q == S_CAPTURE) & ~(full & ~cfg_wrap)));
    assign last_fill = wr_go & ~cfg_wrap & (cap_count == CW'(DEPTH - 1));
    assign rd_go     = rd_en & (state_q == S_DONE) & (cap_count != '0) & ~cfg_arm;

`ifdef NOC_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + TS_WIDTH'(1);
    end

    assign wr_entry = {ts_q, din_msg};
`else
    assign wr_entry = din_msg;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cfg_arm) state_d = S_ARMED;
            S_ARMED: begin
                if (cfg_stop)   state_d = S_DONE;
                else if (wr_go) state_d = last_fill ? S_DONE : S_CAPTURE;
            end
            S_CAPTURE: if (cfg_stop || last_fill || (full && !cfg_wrap)) state_d = S_DONE;
            S_DONE:    if (cfg_arm) state_d = S_ARMED;
            default:   state_d = S_IDLE;
        endcase
    end

    // Trace RAM write port; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_go) mem[wr_ptr] <= wr_entry;
    end

    // Pointers, occupancy, overwrite count and readout register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cap_count <= '0;
            ovf_count <= '0;
            rd_val    <= 1'b0;
            rd_data   <= '0;
        end else if (arm_go) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cap_count <= '0;
            ovf_count <= '0;
            rd_val    <= 1'b0;
        end else begin
            rd_val <= rd_go;
            if (wr_go) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (full) begin
                    rd_ptr <= rd_ptr + AW'(1);
                    if (ovf_count != '1) ovf_count <= ovf_count + OVF_WIDTH'(1);
                end else begin
                    cap_count <= cap_count + CW'(1);
                end
            end else if (rd_go) begin
                rd_ptr    <= rd_ptr + AW'(1);
                cap_count <= cap_count - CW'(1);
`ifdef NOC_TRACE_TIMESTAMP_EN
                rd_data   <= mem[rd_ptr];
`else
                rd_data   <= {{TS_WIDTH{1'b0}}, mem[rd_ptr]};
`endif
            end
        end
    end
endmodule

// File: tb/tb_noc_trace_buffer.sv
// tb/tb_noc_trace_buffer.sv - directed self-checking bench for noc_trace_buffer
module tb_noc_trace_buffer;
    localparam int DW = 16;
    localparam int DP = 8;
    localparam int TW = 16;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din_msg = '0;
    logic          din_val = 1'b0;
    logic          din_yum;
    logic [DW-1:0] dout_msg;
    logic          dout_val;
    logic          dout_yum = 1'b0;
    logic          cfg_arm = 1'b0;
    logic          cfg_stop = 1'b0;
    logic          cfg_wrap = 1'b0;
    logic [DW-1:0] trig_mask = '0;
    logic [DW-1:0] trig_value = '0;
    logic          rd_en = 1'b0;
    logic          rd_val;
    logic [DW+TW-1:0] rd_data;
    logic [1:0]    state;
    logic [$clog2(DP):0] cap_count;
    logic [OW-1:0] ovf_count;

    int checks = 0;
    int errors = 0;
    logic [TW-1:0]    tb_ts = '0;
    logic [DW+TW-1:0] sb[$];

    noc_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .TS_WIDTH(TW), .OVF_WIDTH(OW)) dut (
        .clk(clk), .rst(rst),
        .din_msg(din_msg), .din_val(din_val), .din_yum(din_yum),
        .dout_msg(dout_msg), .dout_val(dout_val), .dout_yum(dout_yum),
        .cfg_arm(cfg_arm), .cfg_stop(cfg_stop), .cfg_wrap(cfg_wrap),
        .trig_mask(trig_mask), .trig_value(trig_value),
        .rd_en(rd_en), .rd_val(rd_val), .rd_data(rd_data),
        .state(state), .cap_count(cap_count), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    // Reference timestamp: counts clocks since the last reset
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW+TW-1:0] entry(input logic [DW-1:0] flit);
`ifdef NOC_TRACE_TIMESTAMP_EN
        return {tb_ts, flit};
`else
        return {{TW{1'b0}}, flit};
`endif
    endfunction

    task automatic send(input logic [DW-1:0] flit, input bit keep);
        din_msg  = flit;
        din_val  = 1'b1;
        dout_yum = 1'b1;
        if (keep) sb.push_back(entry(flit));
        tick();
        din_val  = 1'b0;
        dout_yum = 1'b0;
    endtask

    task automatic pulse_arm();
        cfg_arm = 1'b1;
        tick();
        cfg_arm = 1'b0;
    endtask

    task automatic pulse_stop();
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
    endtask

    task automatic read_one(input string tag);
        logic [DW+TW-1:0] exp;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_rd_val"}, 64'(rd_val), 64'd1);
            chk({tag, "_rd_data"}, 64'(rd_data), 64'(exp));
        end
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_cap", 64'(cap_count), 64'd0);
        chk("rst_ovf", 64'(ovf_count), 64'd0);
        chk("rst_rd_val", 64'(rd_val), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;

        // Transparency with one reset pulse mid-stream
        for (int i = 0; i < 1000; i++) begin
            din_msg  = DW'($urandom);
            din_val  = 1'($urandom);
            dout_yum = 1'($urandom);
            if (i == 500) rst = 1'b1;
            if (i == 503) rst = 1'b0;
            #1;
            chk("pass_msg", 64'(dout_msg), 64'(din_msg));
            chk("pass_val", 64'(dout_val), 64'(din_val));
            chk("pass_yum", 64'(din_yum), 64'(dout_yum));
            tick();
        end
        din_val  = 1'b0;
        dout_yum = 1'b0;
        rst      = 1'b0;
        chk("idle_after_pass", 64'(state), 64'd0);

        // Trigger on 0x2A
        trig_mask  = 16'h00FF;
        trig_value = 16'h002A;
        cfg_wrap   = 1'b0;
        pulse_arm();
        chk("trig_armed", 64'(state), 64'd1);
        send(16'h0010, 1'b0);
        chk("trig_nohit", 64'(state), 64'd1);
        send(16'h002A, 1'b1);
        chk("trig_capture", 64'(state), 64'd2);
        send(16'h002B, 1'b1);
        send(16'h002C, 1'b1);
        pulse_stop();
        chk("trig_done", 64'(state), 64'd3);
        chk("trig_cap", 64'(cap_count), 64'd3);
        for (int i = 0; i < 3; i++) read_one("trig_rd");
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("trig_rd_empty", 64'(rd_val), 64'd0);

        // Stop when full
        trig_mask = '0;
        pulse_arm();
        chk("full_armed_cap", 64'(cap_count), 64'd0);
        for (int i = 1; i <= 12; i++) begin
            send(DW'(i), i <= 8);
            if (i == 7) chk("full_cap7_state", 64'(state), 64'd2);
            if (i == 8) chk("full_done_at8", 64'(state), 64'd3);
        end
        chk("full_cap", 64'(cap_count), 64'd8);
        chk("full_ovf", 64'(ovf_count), 64'd0);
        for (int i = 0; i < 8; i++) read_one("full_rd");
        chk("full_cap_drained", 64'(cap_count), 64'd0);

        // Circular overwrite
        cfg_wrap = 1'b1;
        pulse_arm();
        for (int i = 1; i <= 12; i++) send(DW'(i), i >= 5);
        pulse_stop();
        chk("wrap_cap", 64'(cap_count), 64'd8);
        chk("wrap_ovf", 64'(ovf_count), 64'd4);
        for (int i = 0; i < 8; i++) read_one("wrap_rd");

        // Stalled link: only the yum cycle is a transfer
        cfg_wrap = 1'b0;
        pulse_arm();
        din_msg  = 16'h0077;
        din_val  = 1'b1;
        dout_yum = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_no_write", 64'(cap_count), 64'd0);
        send(16'h0077, 1'b1);
        chk("stall_one", 64'(cap_count), 64'd1);
        pulse_stop();
        chk("stall_cap", 64'(cap_count), 64'd1);
        read_one("stall_rd");

        // Arm and stop together while IDLE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_arm  = 1'b1;
        cfg_stop = 1'b1;
        tick();
        cfg_arm  = 1'b0;
        cfg_stop = 1'b0;
        chk("arm_stop_idle", 64'(state), 64'd1);

        // Reset during capture, then restart
        for (int i = 0; i < 5; i++) send(DW'(16'h50 + i), 1'b0);
        chk("pre_rst_state", 64'(state), 64'd2);
        chk("pre_rst_cap", 64'(cap_count), 64'd5);
        rst = 1'b1;
        #1;
        chk("async_rst_state", 64'(state), 64'd0);
        chk("async_rst_cap", 64'(cap_count), 64'd0);
        tick();
        rst = 1'b0;
        pulse_arm();
        send(16'h00A1, 1'b1);
        send(16'h00A2, 1'b1);
        pulse_stop();
        chk("rearm_cap", 64'(cap_count), 64'd2);
        read_one("rearm_rd");

        // Read and arm together in DONE: arm wins
        rd_en   = 1'b1;
        cfg_arm = 1'b1;
        tick();
        rd_en   = 1'b0;
        cfg_arm = 1'b0;
        sb.delete();
        chk("rd_arm_state", 64'(state), 64'd1);
        chk("rd_arm_rd_val", 64'(rd_val), 64'd0);
        chk("rd_arm_cap", 64'(cap_count), 64'd0);
        pulse_stop();
        chk("stop_armed_done", 64'(state), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
